// File: rtl/stack_op_ctrl_pkg.sv
// Shared opcode constants, FSM encoding and per-opcode stack requirements
// for the data-stack controller.
package stack_ctrl_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_NOP     = 3'd0;
  localparam opcode_t OP_PUSH    = 3'd1;
  localparam opcode_t OP_DROP    = 3'd2;
  localparam opcode_t OP_DUP     = 3'd3;
  localparam opcode_t OP_SWAP    = 3'd4;
  localparam opcode_t OP_OVER    = 3'd5;
  localparam opcode_t OP_REPLACE = 3'd6;
  localparam opcode_t OP_NIP     = 3'd7;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] min_items;  // items that must already be on the stack
    logic       grows;      // depth + 1 on success
    logic       shrinks;    // depth - 1 on success
  } op_info_t;

  function automatic op_info_t op_info(input opcode_t op);
    op_info_t info;
    info = '{min_items: 2'd0, grows: 1'b0, shrinks: 1'b0};
    case (op)
      OP_PUSH:    info = '{min_items: 2'd0, grows: 1'b1, shrinks: 1'b0};
      OP_DROP:    info = '{min_items: 2'd1, grows: 1'b0, shrinks: 1'b1};
      OP_DUP:     info = '{min_items: 2'd1, grows: 1'b1, shrinks: 1'b0};
      OP_SWAP:    info = '{min_items: 2'd2, grows: 1'b0, shrinks: 1'b0};
      OP_OVER:    info = '{min_items: 2'd2, grows: 1'b1, shrinks: 1'b0};
      OP_REPLACE: info = '{min_items: 2'd1, grows: 1'b0, shrinks: 1'b0};
      OP_NIP:     info = '{min_items: 2'd2, grows: 1'b0, shrinks: 1'b1};
      default:    info = '{min_items: 2'd0, grows: 1'b0, shrinks: 1'b0};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/stack_op_ctrl_if.sv
// Decoder-to-stack op request channel: valid/ready handshake plus opcode
// and operand.
interface stack_op_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_data;

  modport master (output op_valid, op, op_data, input  op_ready);
  modport slave  (input  op_valid, op, op_data, output op_ready);
endinterface

// File: rtl/stack_spill_ram.sv
// Single-port synchronous spill RAM for stack entries below tos/nos.
// Reads return one cycle after the address is presented.
module stack_spill_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; clearing it would turn the RAM into a
  // bank of resettable flops. Every location is written before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/stack_op_ctrl.sv
// Data-stack controller: tos/nos cached in registers, deeper entries spilled
// to a synchronous RAM and refilled with a one-cycle REFILL state on pops.
module stack_op_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_op_ctrl_if.slave        op_if,
  output logic [WIDTH-1:0]      tos,
  output logic [WIDTH-1:0]      nos,
  output logic [ADDR_W+1:0]     depth,
  output logic                  empty,
  output logic                  full,
  output logic                  err_overflow,
  output logic                  err_underflow,
  input  logic                  err_clr
);

  localparam int DW = ADDR_W + 2;
  typedef logic [DW-1:0] depth_t;
  localparam depth_t MAXD = depth_t'(2**ADDR_W + 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
  depth_t           depth_q, depth_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  op_info_t         info;
  logic             op_ready, accept, too_few, too_many, exec, refill_start;
  logic             ram_we;
  logic [ADDR_W-1:0] ram_addr, wr_addr, rd_addr;
  logic [WIDTH-1:0] ram_rdata;

  // Op classification and RAM port control.
  // NOTE: every signal assigned in an always_comb gets a value on every
  // path (defaults first where needed) so no latch is inferred.
  always_comb begin
    info     = op_info(op_if.op);
    accept   = op_if.op_valid && op_ready;
    too_few  = depth_q < depth_t'(info.min_items);
    too_many = info.grows && (depth_q == MAXD);
    exec     = accept && !too_few && !too_many;
    refill_start = exec && info.shrinks && (depth_q > depth_t'(2));
    // Spill pointer is depth-2; the third item lives one below it.
    wr_addr  = ADDR_W'(depth_q - depth_t'(2));
    rd_addr  = ADDR_W'(depth_q - depth_t'(3));
    ram_we   = exec && info.grows && (depth_q >= depth_t'(2)) && !reset;
    ram_addr = ram_we ? wr_addr : rd_addr;
  end

  // Datapath next-state.
  always_comb begin
    tos_d   = tos_q;
    nos_d   = nos_q;
    depth_d = depth_q;
    if (state_q == S_REFILL) begin
      nos_d = ram_rdata;
    end else if (exec) begin
      case (op_if.op)
        OP_PUSH:    begin tos_d = op_if.op_data; nos_d = tos_q; depth_d = depth_q + 1'b1; end
        OP_DUP:     begin nos_d = tos_q;                        depth_d = depth_q + 1'b1; end
        OP_OVER:    begin tos_d = nos_q; nos_d = tos_q;         depth_d = depth_q + 1'b1; end
        OP_SWAP:    begin tos_d = nos_q; nos_d = tos_q; end
        OP_REPLACE: begin tos_d = op_if.op_data; end
        // Vacated nos reads 0 until a refill (if any) supplies the new value.
        OP_DROP:    begin tos_d = nos_q; nos_d = '0; depth_d = depth_q - 1'b1; end
        OP_NIP:     begin nos_d = '0;               depth_d = depth_q - 1'b1; end
        default:    ;
      endcase
    end
    // A same-cycle error set wins over err_clr.
    unf_d = (accept && too_few) || (unf_q && !err_clr);
    ovf_d = (accept && !too_few && too_many) || (ovf_q && !err_clr);
  end

  // FSM: next-state.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = refill_start ? S_REFILL : S_IDLE;
      S_REFILL: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    op_ready = (state_q == S_IDLE);
  end

  // FSM: state register.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_spill_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (nos_q),
    .rdata (ram_rdata)
  );

  assign op_if.op_ready = op_ready;
  assign tos            = tos_q;
  assign nos            = nos_q;
  assign depth          = depth_q;
  assign empty          = (depth_q == '0);
  assign full           = (depth_q == MAXD);
  assign err_overflow   = ovf_q;
  assign err_underflow  = unf_q;

endmodule

// File: tb/tb_stack_op_ctrl.sv
// Self-checking bench for stack_op_ctrl: directed scenarios followed by
// random op streams compared against a queue-based stack model.
module tb_stack_op_ctrl;
  import stack_ctrl_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int MAXD   = 2**ADDR_W + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              err_clr;
  logic [WIDTH-1:0]  tos, nos;
  logic [ADDR_W+1:0] depth;
  logic              empty, full, err_overflow, err_underflow;

  stack_op_ctrl_if #(.WIDTH(WIDTH)) op_if ();

  stack_op_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_if         (op_if),
    .tos           (tos),
    .nos           (nos),
    .depth         (depth),
    .empty         (empty),
    .full          (full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: stack contents (last element = top) and sticky flags.
  logic [WIDTH-1:0] stk[$];
  bit               m_ovf, m_unf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_item(input int k);  // k=0 is top
    return (stk.size() > k) ? stk[stk.size()-1-k] : '0;
  endfunction

  task automatic check_state(input string tag);
    logic [ADDR_W-1:0] third_addr;
    check({tag, "_ready"}, op_if.op_ready, 1);
    check({tag, "_tos"},   tos,   m_item(0));
    check({tag, "_nos"},   nos,   m_item(1));
    check({tag, "_depth"}, depth, stk.size());
    check({tag, "_empty"}, empty, stk.size() == 0);
    check({tag, "_full"},  full,  stk.size() == MAXD);
    check({tag, "_ovf"},   err_overflow,  m_ovf);
    check({tag, "_unf"},   err_underflow, m_unf);
    if (stk.size() >= 3) begin
      third_addr = ADDR_W'(stk.size() - 3);
      check({tag, "_third"}, dut.u_ram.mem[third_addr], m_item(2));
    end
  endtask

  task automatic model_step(input bit valid, input logic [2:0] o, input logic [WIDTH-1:0] d,
                            input bit clr, output bit refill);
    int n = stk.size();
    int need = 0;
    bit grow = 0;
    bit set_u = 0, set_o = 0;
    logic [WIDTH-1:0] a, b;
    refill = 0;
    if (valid) begin
      case (o)
        OP_PUSH:    begin need = 0; grow = 1; end
        OP_DROP:    need = 1;
        OP_DUP:     begin need = 1; grow = 1; end
        OP_SWAP:    need = 2;
        OP_OVER:    begin need = 2; grow = 1; end
        OP_REPLACE: need = 1;
        OP_NIP:     need = 2;
        default:    need = 0;
      endcase
      if (n < need) set_u = 1;
      else if (grow && n == MAXD) set_o = 1;
      else begin
        case (o)
          OP_PUSH:    stk.push_back(d);
          OP_DUP:     stk.push_back(stk[n-1]);
          OP_OVER:    stk.push_back(stk[n-2]);
          OP_DROP:    a = stk.pop_back();
          OP_NIP:     begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(a); end
          OP_SWAP:    begin a = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = a; end
          OP_REPLACE: stk[n-1] = d;
          default:    ;
        endcase
        refill = (o == OP_DROP || o == OP_NIP) && n > 2;
      end
    end
    m_unf = set_u | (m_unf & !clr);
    m_ovf = set_o | (m_ovf & !clr);
  endtask

  // One handshake cycle (plus the REFILL cycle when the model expects one).
  task automatic step(input bit valid, input logic [2:0] o, input logic [WIDTH-1:0] d,
                      input bit clr, input string tag);
    bit refill;
    op_if.op_valid = valid;
    op_if.op       = o;
    op_if.op_data  = d;
    err_clr        = clr;
    model_step(valid, o, d, clr, refill);
    @(posedge clk); #1;
    op_if.op_valid = 1'b0;
    err_clr        = 1'b0;
    if (refill) begin
      check({tag, "_refill_busy"}, op_if.op_ready, 0);
      @(posedge clk); #1;
    end
    check_state(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  initial begin
    op_if.op_valid = 1'b0;
    op_if.op       = OP_NOP;
    op_if.op_data  = '0;
    err_clr        = 1'b0;

    do_reset();
    check_state("reset");

    // Basic push / spill / refill.
    step(1, OP_PUSH, 32'h11, 0, "push11");
    step(1, OP_PUSH, 32'h22, 0, "push22");
    step(1, OP_PUSH, 32'h33, 0, "push33");
    check("ram0", dut.u_ram.mem[0], 32'h11);
    step(1, OP_DROP, 0, 0, "drop_a");
    step(1, OP_DROP, 0, 0, "drop_b");
    step(1, OP_DROP, 0, 0, "drop_c");

    // Permutation ops.
    step(1, OP_PUSH, 32'd5, 0, "push5");
    step(1, OP_PUSH, 32'd7, 0, "push7");
    step(1, OP_SWAP, 0, 0, "swap");
    step(1, OP_OVER, 0, 0, "over");
    step(1, OP_DUP,  0, 0, "dup");
    step(1, OP_REPLACE, 32'hABCD, 0, "replace");
    step(1, OP_NIP,  0, 0, "nip_refill");
    while (stk.size() > 0) step(1, OP_DROP, 0, 0, "drain");

    // Underflow and sticky clear.
    step(1, OP_DROP, 0, 0, "unf_drop_empty");
    step(0, OP_NOP,  0, 1, "unf_clr");
    step(1, OP_PUSH, 32'h44, 0, "push44");
    step(1, OP_SWAP, 0, 0, "unf_swap_d1");
    step(1, OP_NIP,  0, 1, "unf_nip_set_beats_clr");
    step(0, OP_NOP,  0, 1, "unf_clr2");
    step(1, OP_DROP, 0, 0, "drop_to_empty");

    // Fill to MAXD, overflow, then pop through the spill RAM.
    for (int i = 1; i <= MAXD; i++) step(1, OP_PUSH, WIDTH'(i), 0, "fill");
    step(1, OP_PUSH, 32'h99, 0, "ovf_push");
    step(1, OP_DUP,  0, 0, "ovf_dup");
    for (int i = 0; i < 32; i++) step(1, OP_DROP, 0, 0, "unfill");
    step(0, OP_NOP, 0, 1, "ovf_clr");

    // Reset landing in the REFILL cycle.
    step(1, OP_PUSH, 32'hA1, 0, "pre_rst_push");
    op_if.op_valid = 1'b1;
    op_if.op       = OP_DROP;
    @(posedge clk); #1;
    op_if.op_valid = 1'b0;
    check("rst_refill_busy", op_if.op_ready, 0);
    reset = 1'b1;
    #1 check("rst_no_ram_we", dut.ram_we, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
    check_state("rst_in_refill");

    // Random streams: push-biased then pop-biased.
    for (int i = 0; i < 700; i++) begin
      bit         v;
      logic [2:0] o;
      v = ($urandom_range(0, 7) != 0);
      o = 3'($urandom_range(0, 7));
      if (i < 350 && $urandom_range(0, 2) == 0) o = OP_PUSH;
      if (i >= 350 && $urandom_range(0, 2) == 0) o = OP_DROP;
      step(v, o, $urandom, ($urandom_range(0, 15) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_op_ctrl.md
Name: stack_op_ctrl

Overview:
Data-stack controller for the Forth-style core. It executes single-word stack operations (PUSH, DROP, DUP, SWAP, OVER, REPLACE, NIP) against a cached top-of-stack/next-on-stack register pair. Deeper entries spill to an internal synchronous RAM. It sits between the instruction decoder, which issues ops over a valid/ready handshake, and the ALU, which reads tos/nos directly.

Parameters:
WIDTH, 32, data word width in bits
ADDR_W, 5, spill RAM address width; RAM holds 2**ADDR_W words; max depth MAXD = 2**ADDR_W + 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  op request present
op_ready  out  1  controller can accept an op this cycle
op  in  3  opcode (see Behaviour)
op_data  in  WIDTH  operand for PUSH/REPLACE
tos  out  WIDTH  top of stack (0 when depth<1)
nos  out  WIDTH  next on stack (0 when depth<2)
depth  out  ADDR_W+2  item count, 0..MAXD
empty  out  1  depth==0
full  out  1  depth==MAXD
err_overflow  out  1  sticky, set on rejected growing op
err_underflow  out  1  sticky, set on rejected op with too few items
err_clr  in  1  clears both sticky error flags

Behaviour:
- Opcodes: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 REPLACE (tos<=op_data), 7 NIP (remove nos).
- Accept = op_valid && op_ready. op_ready = (state==IDLE).
- Reset: state IDLE, tos=0, nos=0, depth=0, both errors 0, op_ready=1 the cycle after reset. RAM contents are not cleared. Reset mid-REFILL aborts the refill.
- Minimum items: PUSH 0, DROP 1, DUP 1, SWAP 2, OVER 2, REPLACE 1, NIP 2. With fewer items the op is consumed in 1 cycle, state is unchanged, and err_underflow is set.
- Growing ops (PUSH, DUP, OVER) when full: consumed in 1 cycle, state is unchanged, and err_overflow is set. Underflow takes priority if both apply.
- Spill pointer sp = max(depth-2, 0). RAM[sp-1] is the third item.
- Growing op: nos<=old tos; tos<=new value (op_data / old tos / old nos). If old depth>=2, RAM[sp]<=old nos and the write completes in the same cycle. depth+1. Single cycle.
- SWAP, REPLACE, NOP: single cycle, depth unchanged.
- DROP: tos<=nos. NIP: tos unchanged. Both decrement depth.
  - If old depth<=2: vacated nos<=0 (and tos<=0 when depth becomes 0). Single cycle.
  - If old depth>2: issue a RAM read of address sp-1 and go to REFILL. In REFILL, nos<=read data, then return to IDLE. Total 2 cycles; op_ready is low in REFILL.
- FSM: IDLE -> REFILL (shrinking op with depth>2 accepted) -> IDLE (unconditionally, next cycle).
- tos, nos, depth, and flags are registered. Values are visible the cycle after accept, except nos after REFILL, which is visible the cycle after REFILL.
- err_clr has priority below a same-cycle error set; setting wins.
- depth arithmetic is unsigned with no wrap; the guards above make wrap unreachable.

Decomposition:
- Package stack_ctrl_pkg: opcode localparams (OP_NOP..OP_NIP), FSM state encoding (S_IDLE, S_REFILL), and a min-items/grows lookup function per opcode.
- One sub-module: stack_spill_ram. It is a single-port synchronous RAM with parameters WIDTH and ADDR_W, ports clk, we, addr, wdata, and rdata, with 1-cycle read latency. Write and read are never issued in the same cycle.

Test Plan:
- Reset then PUSH 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, depth=3, RAM[0]=0x11; each op 1 cycle, op_ready never drops.
- From that state, DROP -> op_ready low 1 cycle; then tos=0x22, nos=0x11, depth=2. DROP, DROP -> depth=0, tos=nos=0, empty=1.
- PUSH 5, PUSH 7, SWAP, OVER -> tos=7, nos=5, third item=7, depth=3. DUP -> depth=4, tos=7, nos=7.
- On empty stack, DROP -> err_underflow=1, depth stays 0; err_clr pulse -> err_underflow=0. SWAP with depth=1 -> err_underflow=1, tos unchanged.
- Fill to MAXD=34 with PUSH 1..34, then PUSH 0x99 -> err_overflow=1, tos=34, full=1. Pop 32 DROPs -> tos/nos sequence 33..2 exact, each DROP 2 cycles.
- Assert reset in REFILL cycle -> next cycle depth=0, tos=nos=0, op_ready=1, no RAM write issued.
